// File: rtl/ht_pkg.sv
// Shared types and helpers for the Hilbert-transform FIR sequencer.
package ht_pkg;

  // Sequencer states: coefficient load, then a sample/MAC/output loop.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_SAMPLE,
    MAC,
    OUTPUT
  } state_e;

  // Result of the output clamp check.
  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HIGH,
    SAT_LOW
  } sat_e;

  // Accumulator must hold LENGTH full-width products without overflow.
  function automatic int accWidth(input int dataWidth, input int length);
    return 2 * dataWidth + $clog2(length);
  endfunction

  // Decides whether a wide signed value fits in a signed field of the
  // given width, and if not, which rail it must be clamped to.
  function automatic sat_e satKind(input logic signed [63:0] value,
                                   input int width);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    sat_e kind;
    maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (width - 1));
    kind = SAT_NONE;
    if (value > maxV) begin
      kind = SAT_HIGH;
    end else if (value < minV) begin
      kind = SAT_LOW;
    end
    return kind;
  endfunction

endpackage

// File: rtl/ht_mac_unit.sv
// Single multiplier-accumulator with shift and saturating output stage.
// The result is a pure function of the accumulator, so it stays stable
// for as long as the accumulator is not enabled or cleared.
module ht_mac_unit
  import ht_pkg::*;
#(
  parameter int LENGTH      = 27,
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_SHIFT = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic signed [DATA_WIDTH-1:0] coeff_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  output logic signed [DATA_WIDTH-1:0] result_o
);

  localparam int ACC_W = accWidth(DATA_WIDTH, LENGTH);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        acc_d;
  logic signed [ACC_W-1:0]        shifted;
  sat_e                           satSel;

  assign product = coeff_i * sample_i;
  assign shifted = acc_q >>> COEFF_SHIFT;
  assign satSel  = satKind(64'(shifted), DATA_WIDTH);

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = acc_q + ACC_W'(product);
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Scale down and clamp to the signed sample range instead of wrapping.
  always_comb begin
    result_o = shifted[DATA_WIDTH-1:0];
    case (satSel)
      SAT_HIGH: result_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      SAT_LOW:  result_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      default:  result_o = shifted[DATA_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/ht_fir_sequencer.sv
// Hilbert-transform FIR sequencer: loads coefficients from the serial
// coefficient generator, then filters samples one product per cycle,
// visiting only the even taps (odd Hilbert taps are zero).
module ht_fir_sequencer
  import ht_pkg::*;
#(
  parameter int LENGTH        = 27,
  parameter int DATA_WIDTH    = 18,
  parameter int COEFF_SHIFT   = 12,
  parameter int CAPTURE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         genEnable,
  input  logic signed [DATA_WIDTH-1:0] coeffIn,
  input  logic                         coeffSetFlag,
  output logic                         loaded,
  output logic                         loadError,
  input  logic signed [DATA_WIDTH-1:0] sampleIn,
  input  logic                         sampleValid,
  output logic                         sampleReady,
  output logic signed [DATA_WIDTH-1:0] dataOut,
  output logic                         dataValid,
  input  logic                         dataReady
);

  localparam int NUM_EVEN = (LENGTH + 1) / 2;
  localparam int TAP_W    = (NUM_EVEN > 1) ? $clog2(NUM_EVEN) : 1;
  localparam int IDX_W    = $clog2(LENGTH);
  localparam int CNT_MAX  = CAPTURE_DELAY + LENGTH;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic                    genEnable_q, genEnable_d;
  logic                    loaded_q, loaded_d;
  logic                    loadError_q, loadError_d;

  logic signed [DATA_WIDTH-1:0] bank_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] x_q    [LENGTH];

  logic             bankWe;
  logic [IDX_W-1:0] bankIdx;
  logic             shiftEn;
  logic             macClear;
  logic             macEnable;
  logic [IDX_W-1:0] tapAddr;

  assign genEnable   = genEnable_q;
  assign loaded      = loaded_q;
  assign loadError   = loadError_q;
  assign sampleReady = (state_q == WAIT_SAMPLE);
  assign dataValid   = (state_q == OUTPUT);
  assign tapAddr     = IDX_W'({tap_q, 1'b0});

  // Next-state and control decode; every control defaults to idle first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tap_d       = tap_q;
    genEnable_d = genEnable_q;
    loaded_d    = loaded_q;
    loadError_d = loadError_q;
    bankWe      = 1'b0;
    bankIdx     = '0;
    shiftEn     = 1'b0;
    macClear    = 1'b0;
    macEnable   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          genEnable_d = 1'b1;
          cnt_d       = '0;
        end
      end
      LOAD: begin
        genEnable_d = 1'b1;
        if (cnt_q == CNT_W'(CNT_MAX)) begin
          genEnable_d = 1'b0;
          loaded_d    = 1'b1;
          state_d     = WAIT_SAMPLE;
          if (!coeffSetFlag) begin
            loadError_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CNT_W'(CAPTURE_DELAY)) begin
            bankWe  = 1'b1;
            bankIdx = IDX_W'(cnt_q - CNT_W'(CAPTURE_DELAY));
          end
        end
      end
      WAIT_SAMPLE: begin
        if (sampleValid) begin
          shiftEn  = 1'b1;
          macClear = 1'b1;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        macEnable = 1'b1;
        if (tap_q == TAP_W'(NUM_EVEN - 1)) begin
          state_d = OUTPUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (dataReady) begin
          state_d = WAIT_SAMPLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset returns to IDLE from any state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tap_q       <= '0;
      genEnable_q <= 1'b0;
      loaded_q    <= 1'b0;
      loadError_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tap_q       <= tap_d;
      genEnable_q <= genEnable_d;
      loaded_q    <= loaded_d;
      loadError_q <= loadError_d;
    end
  end

  // Coefficient bank, filled one entry per cycle during capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LENGTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bankWe) begin
      bank_q[bankIdx] <= coeffIn;
    end
  end

  // Sample delay line, shifted once per accepted sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LENGTH; i++) begin
        x_q[i] <= '0;
      end
    end else if (shiftEn) begin
      x_q[0] <= sampleIn;
      for (int i = 1; i < LENGTH; i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

  ht_mac_unit #(
    .LENGTH      (LENGTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_SHIFT (COEFF_SHIFT)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (macClear),
    .enable_i (macEnable),
    .coeff_i  (bank_q[tapAddr]),
    .sample_i (x_q[tapAddr]),
    .result_o (dataOut)
  );

endmodule

// File: tb/tb_ht_fir_sequencer.sv
// Self-checking bench for ht_fir_sequencer with a behavioural coefficient
// generator and a direct-form FIR reference model.
module tb_ht_fir_sequencer;

  localparam int LEN = 27;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               genEnable;
  logic signed [17:0] coeffIn;
  logic               coeffSetFlag;
  logic               loaded;
  logic               loadError;
  logic signed [17:0] sampleIn;
  logic               sampleValid;
  logic               sampleReady;
  logic signed [17:0] dataOut;
  logic               dataValid;
  logic               dataReady;

  int totalChecks = 0;
  int badChecks   = 0;
  int gcnt        = 0;
  bit flagStuck   = 1'b0;
  int hist [LEN];
  int got;

  int coefTable [LEN] = '{-25, 0, -51, 0, -100, 0, -181, 0, -321, 0, -624, 0,
                          -2018, 0, 2018, 0, 624, 0, 321, 0, 181, 0, 100, 0,
                          51, 0, 25};

  ht_fir_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .genEnable    (genEnable),
    .coeffIn      (coeffIn),
    .coeffSetFlag (coeffSetFlag),
    .loaded       (loaded),
    .loadError    (loadError),
    .sampleIn     (sampleIn),
    .sampleValid  (sampleValid),
    .sampleReady  (sampleReady),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .dataReady    (dataReady)
  );

  always #5 clock = ~clock;

  // Coefficient generator: index 0 appears one cycle after enable rises.
  always @(posedge clock) begin
    if (!genEnable) gcnt <= 0;
    else            gcnt <= gcnt + 1;
  end

  always_comb begin
    coeffIn = '0;
    if (genEnable && gcnt >= 1 && gcnt <= LEN) coeffIn = 18'(coefTable[gcnt-1]);
  end

  assign coeffSetFlag = genEnable && (gcnt >= LEN) && !flagStuck;

  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    totalChecks++;
    if (observed != expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < LEN; i++) hist[i] = 0;
  endfunction

  function automatic void modelPush(input int s);
    for (int i = LEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endfunction

  // y = clamp((sum c[i]*x[n-i]) >> 12) over the full tap set.
  function automatic longint modelOut();
    longint acc = 0;
    for (int i = 0; i < LEN; i++) acc += longint'(coefTable[i]) * longint'(hist[i]);
    acc = acc >>> 12;
    if (acc > 131071)  acc = 131071;
    if (acc < -131072) acc = -131072;
    return acc;
  endfunction

  task automatic applyReset(input int cycles);
    @(negedge clock);
    reset = 1'b0;
    repeat (cycles) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    modelClear();
  endtask

  task automatic doLoad(input int expectError);
    int cyc = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    checkOutput("genEnableRise", genEnable, 1);
    while (!loaded && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("loadCycles", cyc, 29);
    checkOutput("loaded", loaded, 1);
    checkOutput("loadError", loadError, expectError);
    checkOutput("genEnableFall", genEnable, 0);
    checkOutput("readyAfterLoad", sampleReady, 1);
  endtask

  task automatic applyStimulus(input int s, input int holdCycles, output int obs);
    int waitCnt = 0;
    int edges = 0;
    longint expected;
    obs = 0;
    modelPush(s);
    expected = modelOut();
    dataReady = (holdCycles == 0);
    sampleIn = 18'(s);
    sampleValid = 1'b1;
    while (!sampleReady && waitCnt < 100) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!sampleReady) begin
      checkOutput("acceptTimeout", 0, 1);
      sampleValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    sampleValid = 1'b0;
    sampleIn = 18'($urandom);
    @(negedge clock);
    while (!dataValid && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    if (!dataValid) begin
      checkOutput("validTimeout", 0, 1);
      return;
    end
    checkOutput("latency", edges + 1, 15);
    obs = int'(dataOut);
    checkOutput("dataOut", dataOut, expected);
    for (int h = 0; h < holdCycles; h++) begin
      checkOutput("holdValid", dataValid, 1);
      checkOutput("holdReady", sampleReady, 0);
      checkOutput("holdData", dataOut, expected);
      @(negedge clock);
    end
    dataReady = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("validDrop", dataValid, 0);
    checkOutput("readyBack", sampleReady, 1);
  endtask

  function automatic int randSample();
    return int'($urandom_range(262143, 0)) - 131072;
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    sampleIn = '0;
    sampleValid = 1'b0;
    dataReady = 1'b1;
    modelClear();
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkOutput("rstGenEnable", genEnable, 0);
    checkOutput("rstLoaded", loaded, 0);
    checkOutput("rstLoadError", loadError, 0);
    checkOutput("rstSampleReady", sampleReady, 0);
    checkOutput("rstDataValid", dataValid, 0);
    checkOutput("rstDataOut", dataOut, 0);
    reset = 1'b1;

    doLoad(0);

    // start outside IDLE must not restart a load
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    checkOutput("startIgnored", genEnable, 0);
    checkOutput("startIgnoredReady", sampleReady, 1);

    // impulse response reproduces the coefficient bank
    for (int n = 0; n < LEN; n++) begin
      applyStimulus((n == 0) ? 4096 : 0, 0, got);
      checkOutput($sformatf("impulse%0d", n), got, coefTable[n]);
    end

    // random samples with random backpressure, one long stall
    for (int n = 0; n < 10; n++) begin
      applyStimulus(randSample(), (n == 4) ? 20 : int'($urandom_range(3, 0)), got);
    end

    // every product adds with the same sign: positive rail
    for (int n = 0; n < LEN; n++) begin
      applyStimulus(((LEN - 1 - n) <= 12) ? -131071 : 131071, 0, got);
    end
    checkOutput("satHigh", got, 131071);

    // mirrored pattern: negative rail
    for (int n = 0; n < LEN; n++) begin
      applyStimulus(((LEN - 1 - n) <= 12) ? 131071 : -131071, 0, got);
    end
    checkOutput("satLow", got, -131072);

    // reset during the fifth MAC cycle
    @(negedge clock);
    sampleIn = 18'(randSample());
    sampleValid = 1'b1;
    @(posedge clock);
    #1 sampleValid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("midRstGenEnable", genEnable, 0);
    checkOutput("midRstLoaded", loaded, 0);
    checkOutput("midRstSampleReady", sampleReady, 0);
    checkOutput("midRstDataValid", dataValid, 0);
    checkOutput("midRstDataOut", dataOut, 0);
    reset = 1'b1;
    modelClear();
    doLoad(0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus((n == 0) ? 4096 : 0, 0, got);
      checkOutput($sformatf("reloadImpulse%0d", n), got, coefTable[n]);
    end

    // generator never raises its completion flag
    applyReset(2);
    flagStuck = 1'b1;
    doLoad(1);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(randSample(), int'($urandom_range(2, 0)), got);
    end
    checkOutput("loadErrorSticky", loadError, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
